uart_rx_ctrl: RTL and testbench

Frame-level receive controller for the UART receiver. It sequences bit sampling from the 16x oversampling baud tick: start-bit qualification, mid-bit sampling of data, optional parity and stop bit. It then hands each completed byte to the host side over a valid/ready handshake and flags framing and overrun errors. It sits between the baud-rate generator output and the receive FIFO/host logic, replacing free-running edge-triggered capture with a single-clock FSM.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame constants.
// UART_RX_PARITY_EN adds the PARITY state to the receive FSM.
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX line.
// Resets to the idle (high) line level so no false start follows reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic serialInput,
    output logic rxSync
);

    logic meta;

    // Two-stage capture of the line into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            meta   <= serialInput;
            rxSync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start qualification, mid-bit sampling,
// stop/parity checks and host handshake. Parity via UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baudTick,
    input  logic                 serialInput,
    input  logic                 dataReady,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 overrunError,
`ifdef UART_RX_PARITY_EN
    output logic                 parityError,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BLAST = 3'(DATA_BITS - 1);

    rx_state_t state, stateNext;

    logic                 rxSync;
    logic                 rxPrev;
    logic [TW-1:0]        tickCnt;
    logic [2:0]           bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 atHalf;
    logic                 atLast;
    logic                 stopSample;
    logic                 parBad;
    logic                 goodFrame;
    logic                 loadByte;
    logic                 overrun;

    uart_rx_sync uSync (
        .clk        (clk),
        .rst        (rst),
        .serialInput(serialInput),
        .rxSync     (rxSync)
    );

    assign atHalf = (tickCnt == HALF);
    assign atLast = (tickCnt == LAST);
    assign busy   = (state != RX_IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= stateNext;
    end

    // Next-state logic; everything advances only on baudTick
    always_comb begin
        stateNext = state;
        if (baudTick) begin
            unique case (state)
                RX_IDLE:
                    if (rxPrev && !rxSync) stateNext = RX_START;
                RX_START:
                    if (atHalf) stateNext = rxSync ? RX_IDLE : RX_DATA;
                RX_DATA:
`ifdef UART_RX_PARITY_EN
                    if (atLast && bitCnt == BLAST) stateNext = RX_PARITY;
                RX_PARITY:
                    if (atLast) stateNext = RX_STOP;
`else
                    if (atLast && bitCnt == BLAST) stateNext = RX_STOP;
`endif
                RX_STOP:
                    if (atLast) stateNext = RX_IDLE;
                default:
                    stateNext = RX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parityBit;

    // Capture the received parity bit mid-bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parityBit <= 1'b0;
        else if (baudTick && state == RX_PARITY && atLast)
            parityBit <= rxSync;
    end

    assign parBad = (^shiftReg) ^ parityBit;
`else
    assign parBad = 1'b0;
`endif

    // Frame outcome at the stop-bit sample
    always_comb begin
        stopSample = baudTick && (state == RX_STOP) && atLast;
        goodFrame  = stopSample && rxSync && !parBad;
        loadByte   = goodFrame && (!dataValid || dataReady);
        overrun    = goodFrame && dataValid && !dataReady;
    end

    // Tick and bit counters, cleared on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt <= '0;
            bitCnt  <= '0;
        end else if (baudTick) begin
            if (stateNext != state) begin
                tickCnt <= '0;
                bitCnt  <= '0;
            end else if (state != RX_IDLE) begin
                tickCnt <= atLast ? '0 : tickCnt + 1'b1;
                if (state == RX_DATA && atLast)
                    bitCnt <= bitCnt + 1'b1;
            end
        end
    end

    // Edge-detect history and LSB-first data shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxPrev   <= 1'b1;
            shiftReg <= '0;
        end else if (baudTick) begin
            rxPrev <= rxSync;
            if (state == RX_DATA && atLast)
                shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
        end
    end

    // Host handshake and one-clk error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataOut      <= '0;
            dataValid    <= 1'b0;
            frameError   <= 1'b0;
            overrunError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityError  <= 1'b0;
`endif
        end else begin
            frameError   <= stopSample && !rxSync;
            overrunError <= overrun;
`ifdef UART_RX_PARITY_EN
            parityError  <= stopSample && rxSync && parBad;
`endif
            if (loadByte) begin
                dataOut   <= shiftReg;
                dataValid <= 1'b1;
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl, baudTick every clk, 16x oversample.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_ctrl;

`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 8 + PAR;
    localparam int STOP_EDGE = 11 + 16 * (NB + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       baudTick;
    logic       serialInput;
    logic       dataReady;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       frameError;
    logic       overrunError;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parityError;
`endif

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .baudTick    (baudTick),
        .serialInput (serialInput),
        .dataReady   (dataReady),
        .dataOut     (dataOut),
        .dataValid   (dataValid),
        .frameError  (frameError),
        .overrunError(overrunError),
`ifdef UART_RX_PARITY_EN
        .parityError (parityError),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         stopBit;
        bit         parFlip;
        bit         accept;
        bit         push;
        bit         expValid;
        logic [7:0] expOut;
        int         expFe;
        int         expOv;
        int         expPe;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         feCnt = 0;
    int         ovCnt = 0;
    int         peCnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse counters and scoreboard pop on every host acceptance
    always @(negedge clk) begin
        if (!rst) begin
            if (frameError) feCnt++;
            if (overrunError) ovCnt++;
`ifdef UART_RX_PARITY_EN
            if (parityError) peCnt++;
`endif
            if (dataValid && dataReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept: got %0h expected none", dataOut);
                end else begin
                    check("acceptData", int'(dataOut), int'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic sendBit(input logic v);
        serialInput = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit stopBit,
                             input bit parFlip);
        @(posedge clk);
        #1;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        if (PAR == 1) sendBit((^d) ^ parFlip);
        sendBit(stopBit);
        serialInput = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic accept();
        dataReady = 1'b1;
        @(posedge clk);
        #1;
        dataReady = 1'b0;
    endtask

    initial begin
        int   fe0, ov0, pe0;
        logic sawBusy;

        rst = 1'b1;
        baudTick = 1'b1;
        serialInput = 1'b1;
        dataReady = 1'b0;

        vecs.push_back('{8'hA5, 1, 0, 1, 1, 1, 8'hA5, 0, 0, 0});
        vecs.push_back('{8'h3C, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0});
        vecs.push_back('{8'h5A, 1, 0, 1, 1, 1, 8'h5A, 0, 0, 0});
        vecs.push_back('{8'h11, 1, 0, 0, 1, 1, 8'h11, 0, 0, 0});
        vecs.push_back('{8'h22, 1, 0, 1, 0, 1, 8'h11, 0, 1, 0});
        vecs.push_back('{8'h00, 1, 0, 1, 1, 1, 8'h00, 0, 0, 0});
        vecs.push_back('{8'hFF, 1, 0, 1, 1, 1, 8'hFF, 0, 0, 0});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1, 1, 0, 0, 0, 8'h00, 0, 0, 1});
        vecs.push_back('{8'h03, 1, 0, 1, 1, 1, 8'h03, 0, 0, 0});
`endif

        #12;
        check("rstValid", int'(dataValid), 0);
        check("rstOut", int'(dataOut), 0);
        check("rstBusy", int'(busy), 0);
        check("rstFe", int'(frameError), 0);
        check("rstOv", int'(overrunError), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            fe0 = feCnt;
            ov0 = ovCnt;
            pe0 = peCnt;
            if (vecs[k].push) expQ.push_back(vecs[k].data);
            sendFrame(vecs[k].data, vecs[k].stopBit, vecs[k].parFlip);
            check($sformatf("v%0d fe", k), feCnt - fe0, vecs[k].expFe);
            check($sformatf("v%0d ov", k), ovCnt - ov0, vecs[k].expOv);
            check($sformatf("v%0d pe", k), peCnt - pe0, vecs[k].expPe);
            check($sformatf("v%0d valid", k), int'(dataValid),
                  int'(vecs[k].expValid));
            if (vecs[k].expValid)
                check($sformatf("v%0d out", k), int'(dataOut),
                      int'(vecs[k].expOut));
            check($sformatf("v%0d busy", k), int'(busy), 0);
            if (vecs[k].accept) begin
                accept();
                check($sformatf("v%0d clr", k), int'(dataValid), 0);
            end
        end

        // Short low glitch: false start, back to idle silently
        fe0 = feCnt;
        ov0 = ovCnt;
        sawBusy = 1'b0;
        @(posedge clk);
        #1;
        serialInput = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        serialInput = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
        end
        check("glitchBusySeen", int'(sawBusy), 1);
        check("glitchBusy", int'(busy), 0);
        check("glitchValid", int'(dataValid), 0);
        check("glitchErr", feCnt - fe0 + ovCnt - ov0, 0);

        // New byte arrives in the same cycle the held byte is accepted
        expQ.push_back(8'h33);
        sendFrame(8'h33, 1'b1, 1'b0);
        check("ovlHeld", int'(dataValid), 1);
        expQ.push_back(8'h44);
        ov0 = ovCnt;
        fork
            sendFrame(8'h44, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1;
                dataReady = 1'b1;
                @(posedge clk);
                #1;
                dataReady = 1'b0;
            end
        join
        check("ovlNoOverrun", ovCnt - ov0, 0);
        check("ovlValid", int'(dataValid), 1);
        check("ovlOut", int'(dataOut), 8'h44);
        accept();

        // Reset mid-DATA drops the held byte and the frame
        expQ.push_back(8'h77);
        sendFrame(8'h77, 1'b1, 1'b0);
        check("preRstValid", int'(dataValid), 1);
        @(posedge clk);
        #1;
        serialInput = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        serialInput = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midBusy", int'(busy), 1);
        rst = 1'b1;
        #2;
        check("midRstValid", int'(dataValid), 0);
        check("midRstOut", int'(dataOut), 0);
        check("midRstBusy", int'(busy), 0);
        expQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (120) @(posedge clk);
        #1;
        check("postRstIdle", int'(busy), 0);
        expQ.push_back(8'h81);
        sendFrame(8'h81, 1'b1, 1'b0);
        check("postRstValid", int'(dataValid), 1);
        check("postRstOut", int'(dataOut), 8'h81);
        accept();
        check("postRstClr", int'(dataValid), 0);

        check("sbEmpty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
